// File: rtl/composite_pkg.sv
// Shared constants and state type for the composite pixel encoder.
package composite_pkg;

  localparam int unsigned LVL_SYNC          = 0;
  localparam int unsigned LVL_BLANK         = 8;
  localparam int unsigned LVL_BLACK         = 9;
  localparam int unsigned LVL_WHITE         = 31;
  localparam int unsigned FIRST_ACTIVE_LINE = 17;
  localparam int unsigned FLAG_W            = 5;

  // Flag bundle order: {hsync, vsync, hblank, vblank, in_pixel}
  localparam logic [FLAG_W-1:0] FLAGS_BLANK = 5'b00110;

  typedef enum logic [1:0] {
    H_BLANK,
    H_ACTIVE,
    H_DONE
  } h_state_e;

endpackage

// File: rtl/flag_delay_pipe.sv
// Fixed-depth asynchronously reset shift register used to delay timing flags.
module flag_delay_pipe #(
  parameter int unsigned      WIDTH     = 5,
  parameter int unsigned      DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VAL;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/composite_pixel_encoder.sv
// Pixel fetch sequencer and DAC level encoder fed by the NTSC timing generator.
module composite_pixel_encoder
  import composite_pkg::*;
#(
  parameter int unsigned PIXEL_DIV    = 4,
  parameter int unsigned H_PIXELS     = 320,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned LUMA_W       = 4,
  parameter int unsigned DAC_W        = 5,
  parameter int unsigned SYNC_LEVEL   = LVL_SYNC,
  parameter int unsigned BLANK_LEVEL  = LVL_BLANK,
  parameter int unsigned BLACK_LEVEL  = LVL_BLACK,
  parameter int unsigned WHITE_LEVEL  = LVL_WHITE
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_hsync,
  input  logic              i_vsync,
  input  logic              i_hblank,
  input  logic              i_vblank,
  input  logic [9:0]        i_y,
  output logic [8:0]        o_pixel_x,
  output logic [7:0]        o_pixel_y,
  output logic              o_pixel_req,
  input  logic [LUMA_W-1:0] i_pixel_luma,
  output logic [DAC_W-1:0]  o_dac,
  output logic              o_frame_start
);

  localparam int unsigned DIV_W = $clog2(PIXEL_DIV);

  h_state_e           r_state;
  logic [DIV_W-1:0]   r_div;
  logic [8:0]         r_pixel_x;
  logic [7:0]         r_pixel_y;
  logic               r_pixel_req;
  logic               r_hblank_q;
  logic               r_vblank_q;
  logic               r_frame_start;
  logic [LUMA_W-1:0]  r_luma;
  logic [DAC_W-1:0]   r_dac;

  logic               w_abort;
  logic               w_start;
  logic               w_last;
  logic               w_in_pixel;
  logic [7:0]         w_y_rel;
  logic [FLAG_W-1:0]  w_flags_dly;
  logic               w_luma_valid;
  logic [LUMA_W-1:0]  w_luma;
  logic [DAC_W:0]     w_sum;
  logic [DAC_W-1:0]   w_dac_d;

  assign w_abort = i_hblank | i_vblank;
  assign w_start = r_hblank_q & ~i_hblank & ~i_vblank;
  assign w_last  = (r_div == DIV_W'(PIXEL_DIV - 1)) && (r_pixel_x == 9'(H_PIXELS - 1));
  assign w_y_rel = 8'(i_y - 10'(FIRST_ACTIVE_LINE));

  // High when the next clock is part of a pixel period; lines up with the fetched luma.
  assign w_in_pixel = ((r_state == H_BLANK) && w_start) ||
                      ((r_state == H_ACTIVE) && !w_abort && !w_last);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= H_BLANK;
      r_div       <= '0;
      r_pixel_x   <= '0;
      r_pixel_y   <= '0;
      r_pixel_req <= 1'b0;
    end else begin
      r_pixel_req <= 1'b0;
      unique case (r_state)
        H_BLANK: begin
          if (w_start) begin
            r_state     <= H_ACTIVE;
            r_div       <= '0;
            r_pixel_x   <= '0;
            r_pixel_y   <= w_y_rel;
            r_pixel_req <= 1'b1;
          end
        end
        H_ACTIVE: begin
          if (w_abort) begin
            r_state <= H_BLANK;
          end else if (r_div == DIV_W'(PIXEL_DIV - 1)) begin
            r_div <= '0;
            if (r_pixel_x == 9'(H_PIXELS - 1)) begin
              r_state <= H_DONE;
            end else begin
              r_pixel_x   <= r_pixel_x + 9'd1;
              r_pixel_req <= 1'b1;
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        H_DONE: begin
          if (w_abort) r_state <= H_BLANK;
        end
        default: r_state <= H_BLANK;
      endcase
    end
  end

  flag_delay_pipe #(
    .WIDTH     (FLAG_W),
    .DEPTH     (READ_LATENCY + 1),
    .RESET_VAL (FLAGS_BLANK)
  ) u_flag_pipe (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   ({i_hsync, i_vsync, i_hblank, i_vblank, w_in_pixel}),
    .o_q   (w_flags_dly)
  );

  flag_delay_pipe #(
    .WIDTH     (1),
    .DEPTH     (READ_LATENCY),
    .RESET_VAL (1'b0)
  ) u_req_pipe (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (r_pixel_req),
    .o_q   (w_luma_valid)
  );

  assign w_luma = w_luma_valid ? i_pixel_luma : r_luma;
  assign w_sum  = (DAC_W+1)'(BLACK_LEVEL) + (DAC_W+1)'(w_luma);

  always_comb begin
    w_dac_d = DAC_W'(BLACK_LEVEL);
    if (w_flags_dly[4] | w_flags_dly[3]) begin
      w_dac_d = DAC_W'(SYNC_LEVEL);
    end else if (w_flags_dly[2] | w_flags_dly[1]) begin
      w_dac_d = DAC_W'(BLANK_LEVEL);
    end else if (!w_flags_dly[0]) begin
      w_dac_d = DAC_W'(BLACK_LEVEL);
    end else if (w_sum > (DAC_W+1)'(WHITE_LEVEL)) begin
      w_dac_d = DAC_W'(WHITE_LEVEL);
    end else begin
      w_dac_d = w_sum[DAC_W-1:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_luma        <= '0;
      r_dac         <= DAC_W'(BLANK_LEVEL);
      r_hblank_q    <= 1'b0;
      r_vblank_q    <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_luma        <= w_luma;
      r_dac         <= w_dac_d;
      r_hblank_q    <= i_hblank;
      r_vblank_q    <= i_vblank;
      r_frame_start <= r_vblank_q & ~i_vblank;
    end
  end

  assign o_pixel_x     = r_pixel_x;
  assign o_pixel_y     = r_pixel_y;
  assign o_pixel_req   = r_pixel_req;
  assign o_dac         = r_dac;
  assign o_frame_start = r_frame_start;

endmodule
